// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - job request and array/result drive bundle for systolic_ctrl
// reuse_w exists only when SA_CTRL_WEIGHT_REUSE_EN is defined.
interface systolic_ctrl_if #(
  parameter int N  = 4,
  parameter int VW = 8
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic              start;
  logic [VW-1:0]     num_vec;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  logic              reuse_w;
`endif
  logic              busy;
  logic              done;
  logic              load_en;
  logic [AW-1:0]     w_rd_addr;
  logic [VW-1:0]     a_rd_addr;
  logic [N-1:0]      row_en;
  logic [N-1:0]      col_valid;
  logic [VW*N-1:0]   res_wr_addr;

  modport master (
    output start, num_vec,
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    output reuse_w,
`endif
    input  busy, done, load_en, w_rd_addr, a_rd_addr, row_en, col_valid, res_wr_addr
  );

  modport slave (
    input  start, num_vec,
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    input  reuse_w,
`endif
    output busy, done, load_en, w_rd_addr, a_rd_addr, row_en, col_valid, res_wr_addr
  );
endinterface

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - load/stream/drain sequencer for an NxN weight-stationary MAC array
// Optional weight reuse (skip LOAD) enabled by defining SA_CTRL_WEIGHT_REUSE_EN.
module systolic_ctrl #(
  parameter int N  = 4,
  parameter int VW = 8
) (
  input  logic           clk,
  input  logic           rst,
  systolic_ctrl_if.slave bus
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = VW + $clog2(N) + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]      state, state_n;
  logic [TW-1:0]   cnt, cnt_n;
  logic [VW-1:0]   nv, nv_n;
  logic            reuse_ok;

  logic            busy_q, done_q, load_en_q;
  logic [AW-1:0]   w_rd_addr_q, w_rd_addr_n;
  logic [VW-1:0]   a_rd_addr_q, a_rd_addr_n;
  logic [N-1:0]    row_en_n, row_en_q;
  logic [N-1:0]    col_valid_n, col_valid_q;
  logic [VW*N-1:0] res_n, res_q;
  logic            run_n;
  logic [TW-1:0]   nv_w;

`ifdef SA_CTRL_WEIGHT_REUSE_EN
  // Weights are only trusted once a full LOAD has completed since reset.
  logic w_loaded;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_loaded <= 1'b0;
    end else if (state == S_LOAD && cnt == TW'(N - 1)) begin
      w_loaded <= 1'b1;
    end
  end

  assign reuse_ok = bus.reuse_w && w_loaded;
`else
  assign reuse_ok = 1'b0;
`endif

  // cnt is the LOAD cycle index in LOAD and the stream-relative cycle in STREAM/DRAIN.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    nv_n    = nv;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          nv_n  = bus.num_vec;
          cnt_n = '0;
          if (bus.num_vec == '0) begin
            state_n = S_DONE;
          end else if (reuse_ok) begin
            state_n = S_STREAM;
          end else begin
            state_n = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (cnt == TW'(N - 1)) begin
          state_n = S_STREAM;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STREAM: begin
        cnt_n = cnt + 1'b1;
        if (cnt == TW'(nv) - 1'b1) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt == TW'(nv) + TW'(2 * N - 2)) begin
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so they can be registered without lag.
  always_comb begin
    run_n       = (state_n == S_STREAM) || (state_n == S_DRAIN);
    nv_w        = TW'(nv_n);
    w_rd_addr_n = w_rd_addr_q;
    a_rd_addr_n = a_rd_addr_q;
    row_en_n    = '0;
    col_valid_n = '0;
    res_n       = res_q;
    if (state_n == S_LOAD) begin
      w_rd_addr_n = AW'(N - 1) - AW'(cnt_n);
    end
    if (state_n == S_STREAM) begin
      a_rd_addr_n = VW'(cnt_n);
    end
    for (int r = 0; r < N; r++) begin
      row_en_n[r]    = run_n && (cnt_n >= TW'(r)) && (cnt_n < TW'(r) + nv_w);
      col_valid_n[r] = run_n && (cnt_n >= TW'(N + r)) && (cnt_n < TW'(N + r) + nv_w);
      if (col_valid_n[r]) begin
        res_n[r*VW +: VW] = VW'(cnt_n - TW'(N + r));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      nv          <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_en_q   <= 1'b0;
      w_rd_addr_q <= '0;
      a_rd_addr_q <= '0;
      row_en_q    <= '0;
      col_valid_q <= '0;
      res_q       <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      nv          <= nv_n;
      busy_q      <= (state_n != S_IDLE);
      done_q      <= (state_n == S_DONE);
      load_en_q   <= (state_n == S_LOAD);
      w_rd_addr_q <= w_rd_addr_n;
      a_rd_addr_q <= a_rd_addr_n;
      row_en_q    <= row_en_n;
      col_valid_q <= col_valid_n;
      res_q       <= res_n;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.load_en     = load_en_q;
  assign bus.w_rd_addr   = w_rd_addr_q;
  assign bus.a_rd_addr   = a_rd_addr_q;
  assign bus.row_en      = row_en_q;
  assign bus.col_valid   = col_valid_q;
  assign bus.res_wr_addr = res_q;
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - directed and random job sequences checked against a cycle-timeline model
// Build with SA_CTRL_WEIGHT_REUSE_EN defined to exercise weight reuse.
module tb_systolic_ctrl;
  localparam int N  = 4;
  localparam int VW = 8;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  localparam bit REUSE_BUILT = 1'b1;
`else
  localparam bit REUSE_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_ctrl_if #(.N(N), .VW(VW)) bus ();
  systolic_ctrl #(.N(N), .VW(VW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;

  // Model: one job described by its accept cycle, vector count and load length.
  bit jv = 1'b0;
  bit wloaded = 1'b0;
  int s0, jnv, jl, t0, dcyc;
  logic [AW-1:0] e_w;
  logic [VW-1:0] e_a;
  logic [VW-1:0] e_res [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, k, got, exp);
  endtask

  task automatic step(input bit st, input int nv, input bit rs, input bit ru);
    logic          e_busy, e_done, e_load;
    logic [N-1:0]  e_row, e_col;
    logic [VW*N-1:0] e_pack;
    int t;
    @(negedge clk);
    bus.start   = st;
    bus.num_vec = VW'(nv);
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    bus.reuse_w = ru;
`endif
    rst = rs;
    @(posedge clk);
    if (rs) begin
      jv = 1'b0;
      wloaded = 1'b0;
      e_w = '0;
      e_a = '0;
      for (int c = 0; c < N; c++) e_res[c] = '0;
    end else begin
      if (jv && jl == N && jnv != 0 && k == s0 + N) wloaded = 1'b1;
      if ((!jv || k > dcyc) && st) begin
        jv   = 1'b1;
        s0   = k;
        jnv  = nv;
        jl   = (REUSE_BUILT && ru && wloaded) ? 0 : N;
        t0   = s0 + 1 + jl;
        dcyc = (jnv == 0) ? s0 + 1 : t0 + jnv + 2 * N - 1;
      end
    end
    k++;
    #1;
    e_busy = 1'b0; e_done = 1'b0; e_load = 1'b0; e_row = '0; e_col = '0;
    if (jv && k > s0 && k <= dcyc) begin
      e_busy = 1'b1;
      e_done = (k == dcyc);
      if (jnv != 0) begin
        if (k <= s0 + jl) begin
          e_load = 1'b1;
          e_w = AW'(N + s0 - k);
        end
        t = k - t0;
        if (t >= 0 && t < jnv) e_a = VW'(t);
        for (int r = 0; r < N; r++) begin
          if (t >= r && t < r + jnv) e_row[r] = 1'b1;
          if (t >= N + r && t < N + r + jnv) begin
            e_col[r] = 1'b1;
            e_res[r] = VW'(t - N - r);
          end
        end
      end
    end
    for (int c = 0; c < N; c++) e_pack[c*VW +: VW] = e_res[c];
    check("busy", 64'(bus.busy), 64'(e_busy));
    check("done", 64'(bus.done), 64'(e_done));
    check("load_en", 64'(bus.load_en), 64'(e_load));
    check("w_rd_addr", 64'(bus.w_rd_addr), 64'(e_w));
    check("a_rd_addr", 64'(bus.a_rd_addr), 64'(e_a));
    check("row_en", 64'(bus.row_en), 64'(e_row));
    check("col_valid", 64'(bus.col_valid), 64'(e_col));
    check("res_wr_addr", 64'(bus.res_wr_addr), 64'(e_pack));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.num_vec = '0;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    bus.reuse_w = 1'b0;
`endif
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 3, 1'b0, 1'b1);
    idle(14);
    step(1'b1, 0, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 3, 1'b0, 1'b1);
    idle(16);
    step(1'b1, 3, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    idle(18);
    step(1'b1, 4, 1'b0, 1'b0);
    idle(6);
    step(1'b1, 7, 1'b0, 1'b0);
    idle(18);
    step(1'b1, 1, 1'b0, 1'b0);
    idle(13);
    step(1'b1, 1, 1'b0, 1'b0);
    idle(16);
    step(1'b1, 255, 1'b0, 1'b0);
    idle(272);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9),
           $urandom_range(0, 80) == 0, 1'($urandom_range(0, 1)));
    end
    idle(30);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
